fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: width of each requester data word and of the FIFO write data.
REQ-002 The block SHALL have parameter DEPTH, default 8: entry count of the downstream FIFO; legal range 2..15.
REQ-003 The block SHALL have port Clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port Rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port REQ, input, 4 bits: per-requester write request, bit i for requester i.
REQ-006 The block SHALL have port DIN, input, 4*DATA_W bits: requester i data on bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port RD, input, 1 bit: the FIFO read strobe driven by the consumer, monitored only.
REQ-008 The block SHALL have port FULL, input, 1 bit: the FIFO full flag, monitored only.
REQ-009 The block SHALL have port GNT, output, 4 bits: one-hot grant, bit i acknowledges requester i.
REQ-010 The block SHALL have port FIFO_EN, output, 1 bit: the FIFO enable.
REQ-011 The block SHALL have port FIFO_WR, output, 1 bit: the FIFO write strobe.
REQ-012 The block SHALL have port FIFO_DIN, output, DATA_W bits: the FIFO write data.
REQ-013 The block SHALL have port LEVEL, output, 4 bits: tracked FIFO occupancy.
REQ-014 The block SHALL have port OVF, output, 1 bit: sticky overflow error flag.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 FIFO_EN SHALL be 1 in every cycle after reset deassertion.
REQ-017 At each rising edge the block SHALL compute next = LEVEL + FIFO_WR - (RD && LEVEL!=0), and SHALL load LEVEL with next.
REQ-018 The block SHALL issue a grant at an edge only if next < DEPTH and at least one eligible REQ bit is 1.
REQ-019 A requester whose GNT bit is currently 1 SHALL be ineligible at that edge, so no requester is granted in two consecutive cycles.
REQ-020 Arbitration SHALL be round-robin: the search starts at the requester after the last granted one, wrapping 3->0.
REQ-021 Latency SHALL be one cycle: a grant decided at edge k drives GNT[i]=1, FIFO_WR=1 and FIFO_DIN=DIN[i] during cycle k+1; the write lands in the FIFO at edge k+1.
REQ-022 When no grant is issued, GNT SHALL be 0, FIFO_WR SHALL be 0, and FIFO_DIN SHALL hold its previous value.
REQ-023 Requester handshake: hold REQ and DIN stable until GNT[i] is seen; then drop REQ or present new data by the following edge.
REQ-024 A simultaneous write and read SHALL leave LEVEL unchanged; a read with LEVEL=0 SHALL be ignored.
REQ-025 If FULL=1 in a cycle where FIFO_WR=1, OVF SHALL set at that edge and hold until reset.
REQ-026 REQ deasserted before grant SHALL withdraw the request without side effects.

Reset
REQ-027 While Rst_n=0, GNT, FIFO_WR, FIFO_EN, FIFO_DIN, LEVEL and OVF SHALL be 0, and the round-robin pointer SHALL select requester 0 as first candidate.
REQ-028 Reset asserted mid-write SHALL abort the write immediately; the FIFO is reset on the same Rst_n.

Configuration
REQ-029 With macro FIFO_ARB_PRIORITY_EN defined, requester 0 SHALL win whenever eligible, and requesters 1..3 SHALL be served round-robin among themselves; undefined gives pure round-robin over 0..3 (REQ-020).

Verification
REQ-030 Verification SHALL cover: REQ=4'b0001, DIN0=8'h11 held, no reads -> GNT=0001 every other cycle, writes 11 x8, LEVEL stops at 8, OVF=0.
REQ-031 Verification SHALL cover: REQ=4'b1111, data 8'hA0..A3, RD=1 continuous -> grant order 0,1,2,3,0...; FIFO_WR=1 every cycle; LEVEL steady at 0-1.
REQ-032 Verification SHALL cover: LEVEL=7, REQ=4'b0110, no read -> exactly one grant (requester 1); LEVEL=8; no further grant until RD pulse, then requester 2 granted.
REQ-033 Verification SHALL cover: LEVEL=8 with RD=1 and REQ=4'b0001 at the same edge -> grant issued, LEVEL stays 8 after the write.
REQ-034 Verification SHALL cover: force FULL=1 during a granted write -> OVF=1 next cycle and stays 1 until Rst_n=0.
REQ-035 Verification SHALL cover: Rst_n low for 3ns mid-write -> all outputs 0 asynchronously; after release, first grant goes to requester 0 (and, with FIFO_ARB_PRIORITY_EN, requester 0 always beats REQ=4'b1111).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Four-requester write arbiter for a downstream FIFO: tracks occupancy, issues one-cycle registered grants.
// Optional macro FIFO_ARB_PRIORITY_EN: requester 0 has fixed priority, requesters 1..3 share round-robin.
module fifo_wr_arbiter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [3:0]            REQ,
  input  logic [4*DATA_W-1:0]   DIN,
  input  logic                  RD,
  input  logic                  FULL,
  output logic [3:0]            GNT,
  output logic                  FIFO_EN,
  output logic                  FIFO_WR,
  output logic [DATA_W-1:0]     FIFO_DIN,
  output logic [3:0]            LEVEL,
  output logic                  OVF
);

  logic [3:0]        r_gnt;
  logic              r_wr;
  logic              r_en;
  logic [DATA_W-1:0] r_din;
  logic [3:0]        r_level;
  logic              r_ovf;
  logic [1:0]        r_ptr;

  logic              w_rd_eff;
  logic [4:0]        w_next;
  logic              w_space;
  logic [3:0]        w_elig;
  logic              w_found;
  logic [1:0]        w_win;
  logic              w_grant;
  logic [DATA_W-1:0] w_din_arr [4];

  for (genvar g = 0; g < 4; g++) begin : g_din
    assign w_din_arr[g] = DIN[g*DATA_W +: DATA_W];
  end

  // Occupancy after this edge's in-flight write and (non-empty) read.
  assign w_rd_eff = RD && (r_level != 4'd0);
  assign w_next   = {1'b0, r_level} + {4'd0, r_wr} - {4'd0, w_rd_eff};
  assign w_space  = (w_next < 5'(DEPTH));
  assign w_elig   = REQ & ~r_gnt;
  assign w_grant  = w_found && w_space;

`ifdef FIFO_ARB_PRIORITY_EN
  logic [2:0] w_sum;

  // r_ptr holds the first round-robin candidate among 1..3.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_sum   = 3'd0;
    if (w_elig[0]) begin
      w_found = 1'b1;
    end else begin
      for (int d = 0; d < 3; d++) begin
        w_sum = {1'b0, r_ptr} + 3'(d);
        if (w_sum > 3'd3) w_sum = w_sum - 3'd3;
        if (!w_found && w_elig[w_sum[1:0]]) begin
          w_found = 1'b1;
          w_win   = w_sum[1:0];
        end
      end
    end
  end
`else
  logic [1:0] w_cand;

  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_cand  = 2'd0;
    for (int d = 0; d < 4; d++) begin
      w_cand = r_ptr + 2'(d);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_gnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_en    <= 1'b0;
      r_din   <= '0;
      r_level <= 4'd0;
      r_ovf   <= 1'b0;
`ifdef FIFO_ARB_PRIORITY_EN
      r_ptr   <= 2'd1;
`else
      r_ptr   <= 2'd0;
`endif
    end else begin
      r_en    <= 1'b1;
      r_level <= w_next[3:0];
      if (r_wr && FULL) r_ovf <= 1'b1;
      if (w_grant) begin
        r_gnt <= 4'b0001 << w_win;
        r_wr  <= 1'b1;
        r_din <= w_din_arr[w_win];
`ifdef FIFO_ARB_PRIORITY_EN
        if (w_win != 2'd0) r_ptr <= (w_win == 2'd3) ? 2'd1 : w_win + 2'd1;
`else
        r_ptr <= w_win + 2'd1;
`endif
      end else begin
        r_gnt <= 4'd0;
        r_wr  <= 1'b0;
      end
    end
  end

  assign GNT      = r_gnt;
  assign FIFO_EN  = r_en;
  assign FIFO_WR  = r_wr;
  assign FIFO_DIN = r_din;
  assign LEVEL    = r_level;
  assign OVF      = r_ovf;

endmodule
